// File: rtl/accu_tx.sv
// accu_tx: buffers 32-bit words in a small FIFO and serializes each one as
// four bytes (byte0 first) toward a downstream byte accumulator.
// Optional feature macro: ACCU_TX_SUM_EN adds sum_out/sum_valid, which report
// the byte sum of each word together with its last byte.
module accu_tx #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        pause,
    output logic        valid_out,
    output logic [7:0]  data_out,
    output logic        last_out
`ifdef ACCU_TX_SUM_EN
    ,
    output logic [9:0]  sum_out,
    output logic        sum_valid
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    state_t        r_state;
    state_t        w_stateNext;
    logic [31:0]   r_word;
    logic [1:0]    r_idx;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_emit;
    logic [7:0]    w_byte;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never reopens a full FIFO.
    assign word_ready = (r_count != FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = word_valid && word_ready;

    // FIFO storage: written on an accepted word, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= word_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state, FIFO pop and byte-emit decisions; the last byte of a word
    // loads the next word at the same edge so words stream back to back.
    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_stateNext = SEND;
                    w_pop       = 1'b1;
                end
            end
            SEND: begin
                if (!pause) begin
                    w_emit = 1'b1;
                    if (r_idx == 2'd3) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Select the byte at the current index of the loaded word.
    always_comb begin
        w_byte = r_word[7:0];
        case (r_idx)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
    end

    // Registered byte outputs, byte index and loaded word; data holds while
    // idle or paused so the stalled byte stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= 8'h00;
            r_idx     <= 2'd0;
            r_word    <= 32'h0;
        end else begin
            valid_out <= w_emit;
            last_out  <= w_emit && (r_idx == 2'd3);
            if (w_emit) begin
                data_out <= w_byte;
                r_idx    <= r_idx + 2'd1;
            end
            if (w_pop) begin
                r_word <= r_mem[r_rdPtr];
                r_idx  <= 2'd0;
            end
        end
    end

`ifdef ACCU_TX_SUM_EN
    logic [9:0] w_sum;

    assign w_sum = {2'b00, r_word[7:0]} + {2'b00, r_word[15:8]}
                 + {2'b00, r_word[23:16]} + {2'b00, r_word[31:24]};

    // Word byte sum, published alongside the last byte and held in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= 10'd0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= w_emit && (r_idx == 2'd3);
            if (w_emit && (r_idx == 2'd3)) begin
                sum_out <= w_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accu_tx.sv
// Testbench for accu_tx: directed words, expected bytes queued at acceptance
// and compared by an independent monitor whenever valid_out is high.
module tb_accu_tx;

    logic        clk;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        pause;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        last_out;
`ifdef ACCU_TX_SUM_EN
    logic [9:0]  sum_out;
    logic        sum_valid;
    logic [9:0]  sumQ[$];
`endif

    logic [8:0]  expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          runLen = 0;
    int          maxRun = 0;

    accu_tx #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .pause      (pause),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .last_out   (last_out)
`ifdef ACCU_TX_SUM_EN
        ,
        .sum_out    (sum_out),
        .sum_valid  (sum_valid)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one word and hold it until accepted; expected bytes are queued
    // at the edge that takes it. waits counts rejected edges.
    task automatic applyStimulus(input logic [31:0] w, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits = 0;
        @(negedge clk);
        word_in = w;
        word_valid = 1'b1;
        while (!accepted && waits < 50) begin
            if (word_ready) begin
                accepted = 1'b1;
                expQ.push_back({1'b0, w[7:0]});
                expQ.push_back({1'b0, w[15:8]});
                expQ.push_back({1'b0, w[23:16]});
                expQ.push_back({1'b1, w[31:24]});
`ifdef ACCU_TX_SUM_EN
                sumQ.push_back({2'b00, w[7:0]} + {2'b00, w[15:8]} + {2'b00, w[23:16]} + {2'b00, w[31:24]});
`endif
            end
            @(posedge clk);
            #1;
            if (!accepted) begin
                waits++;
                @(negedge clk);
            end
        end
        word_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL push_timeout actual=not_accepted required=accepted word=%08h", w);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0 bytes pending", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Wait for a given byte to appear on the output, bounded.
    task automatic waitByte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (valid_out && data_out == b) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_byte actual=absent required=%02h", b);
        end
    endtask

    // Monitor: compares every emitted byte against the scoreboard and tracks
    // the longest run of consecutive valid cycles.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && valid_out) begin
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_byte actual=%02h required=none", data_out);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("byte_data", {24'h0, data_out}, {24'h0, exp[7:0]});
                    checkOutput("byte_last", {31'h0, last_out}, {31'h0, exp[8]});
                end
            end else begin
                runLen = 0;
            end
`ifdef ACCU_TX_SUM_EN
            if (rst_n && sum_valid) begin
                checkOutput("sum_with_last", {31'h0, sum_valid}, {31'h0, last_out});
                if (sumQ.size() != 0) begin
                    checkOutput("sum_value", {22'h0, sum_out}, {22'h0, sumQ.pop_front()});
                end
            end
`endif
        end
    end

    initial begin
        int waits;
        int idleValid;
        rst_n = 1'b0;
        word_in = 32'h0;
        word_valid = 1'b0;
        pause = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("rst_last", {31'h0, last_out}, 32'h0);
        checkOutput("rst_data", {24'h0, data_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, word_ready}, 32'h1);

        // Single word, latency of two cycles to byte0
        applyStimulus(32'h04030201, waits);
        @(negedge clk);
        checkOutput("lat_cycle1_valid", {31'h0, valid_out}, 32'h0);
        @(negedge clk);
        checkOutput("lat_cycle2_valid", {31'h0, valid_out}, 32'h0);
        @(negedge clk);
        checkOutput("lat_byte0_valid", {31'h0, valid_out}, 32'h1);
        checkOutput("lat_byte0_data", {24'h0, data_out}, 32'h01);
        waitDrain();
        checkOutput("single_run", maxRun, 4);

        // All-ones word
        applyStimulus(32'hFFFFFFFF, waits);
        waitDrain();

        // Three words back to back fill the FIFO and stream gap-free
        applyStimulus(32'h13121110, waits);
        applyStimulus(32'h23222120, waits);
        applyStimulus(32'h33323130, waits);
        checkOutput("full_ready_low", {31'h0, word_ready}, 32'h0);
        waitDrain();
        checkOutput("three_word_run", maxRun, 12);

        // Push at full while a pop happens: rejected until the edge after
        applyStimulus(32'h43424140, waits);
        applyStimulus(32'h53525150, waits);
        applyStimulus(32'h63626160, waits);
        applyStimulus(32'h73727170, waits);
        checkOutput("full_push_waits", waits, 3);
        waitDrain();
        checkOutput("four_word_run", maxRun, 16);

        // Pause for three cycles after byte1
        applyStimulus(32'hDDCCBBAA, waits);
        waitByte(8'hBB);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("pause_valid_low", {31'h0, valid_out}, 32'h0);
            checkOutput("pause_data_hold", {24'h0, data_out}, 32'hBB);
        end
        pause = 1'b0;
        @(negedge clk);
        checkOutput("resume_data", {24'h0, data_out}, 32'hCC);
        waitDrain();

        // Reset after byte2 with a second word buffered
        applyStimulus(32'h44332211, waits);
        applyStimulus(32'h88776655, waits);
        waitByte(8'h33);
        rst_n = 1'b0;
        #1;
        expQ.delete();
`ifdef ACCU_TX_SUM_EN
        sumQ.delete();
`endif
        checkOutput("midrst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("midrst_last", {31'h0, last_out}, 32'h0);
        checkOutput("midrst_data", {24'h0, data_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleValid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out) idleValid++;
        end
        checkOutput("post_rst_idle", idleValid, 0);
        checkOutput("post_rst_ready", {31'h0, word_ready}, 32'h1);
        applyStimulus(32'h0C0B0A09, waits);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_rst_byte0", {24'h0, data_out}, 32'h09);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accu_tx.md
ACCU_TX -- requirements
Module: accu_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of 32-bit input words buffered; SHALL be a power of two, >= 2.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 word_in  input  32  four bytes to transmit; byte0 = word_in[7:0], byte3 = word_in[31:24].
REQ-006 word_valid  input  1  word_in is valid.
REQ-007 word_ready  output  1  block can accept a word this cycle.
REQ-008 pause  input  1  downstream stall request; emission suspended while high.
REQ-009 valid_out  output  1  data_out carries a byte this cycle (feeds the accumulator's valid_in).
REQ-010 data_out  output  8  transmitted byte (feeds the accumulator's data_in).
REQ-011 last_out  output  1  high with the fourth byte of each word.

Function
REQ-012 A word SHALL be accepted at a rising edge where word_valid && word_ready are both high; otherwise word_in is ignored.
REQ-013 word_ready SHALL equal !full, derived from registered FIFO occupancy only; no combinational path from word_valid or pause.
REQ-014 When full, word_ready SHALL stay low even if a word is popped in the same cycle (no full-cycle pass-through).
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH and SHALL be unchanged on a simultaneous push and pop.
REQ-016 Serializer FSM states: IDLE (no word loaded) and SEND (word loaded, byte index idx 0..3).
REQ-017 IDLE -> SEND: at an edge where the FIFO is non-empty; the head word is popped into a shift register with idx=0.
REQ-018 In SEND at an edge with pause low: valid_out<=1, data_out<=byte idx, last_out<=(idx==3), idx<=idx+1.
REQ-019 On emitting idx==3, SHALL load the next FIFO word at the same edge if available (staying in SEND, idx=0), else return to IDLE; consecutive words therefore stream with no idle cycle.
REQ-020 At any edge with pause high, or in IDLE: valid_out<=0, last_out<=0, data_out and idx hold; emission resumes at the held idx when pause falls.
REQ-021 Latency: a word pushed into an empty FIFO with the serializer IDLE and pause low SHALL produce byte0 with valid_out high in the second cycle after the accepting edge, bytes 1..3 in the next three cycles.
REQ-022 All outputs except word_ready SHALL be registered.
REQ-023 Byte order SHALL be strictly byte0..byte3 per word and words in acceptance order; no word dropped or duplicated.

Reset
REQ-024 On rst_n low: valid_out=0, last_out=0, data_out=8'h00, idx=0, FSM=IDLE, FIFO empty, word_ready=1 after release.
REQ-025 Reset mid-word SHALL discard the partial word and all buffered words; first activity after release is the next accepted word's byte0.

Configuration
REQ-026 Macro ACCU_TX_SUM_EN: when defined, adds outputs sum_out (10 bits) and sum_valid (1 bit).
REQ-027 With ACCU_TX_SUM_EN: sum_valid SHALL pulse with last_out and sum_out SHALL equal the zero-extended sum of that word's four bytes (max 1020, no overflow); both reset to 0; sum_out holds between pulses.
REQ-028 Without ACCU_TX_SUM_EN: ports and sum logic absent; all other behaviour identical.

Verification
REQ-029 Single word 32'h04030201, pause low -> valid_out high four consecutive cycles, data_out 01,02,03,04, last_out with 04; sum_out=10 with sum_valid if enabled.
REQ-030 Three words pushed back-to-back (FIFO_DEPTH=2) -> word_ready low when full, 12 consecutive valid bytes, no gap between words.
REQ-031 Word 32'hFFFFFFFF -> four bytes FF; sum_out=1020 (10'h3FC) if enabled.
REQ-032 pause high for 3 cycles after byte1 of 32'hDDCCBBAA -> valid_out low 3 cycles, data_out holds BB, then CC, DD resume with last_out on DD.
REQ-033 rst_n asserted after byte2 of a word with one more word buffered -> outputs zero immediately; after release no further bytes until a new word is pushed.
REQ-034 Push at full while a pop occurs in same cycle -> word_ready low that cycle, word not accepted, stream intact.
